// File: rtl/fios_operand_server.sv
// Operand/result buffer between the host bus adapter and the FIOS core.
// Optional sticky protocol-error flag err_o when FIOS_OPSRV_ERR_EN is defined.
module fios_operand_server #(
    parameter int s     = 8,
    parameter int PE_NB = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  ld_valid_i,
    input  logic [1:0]            ld_sel_i,
    input  logic [16:0]           ld_data_i,
    output logic                  ld_ready_o,
    input  logic                  go_i,
    output logic                  busy_o,
    output logic                  start_o,
    output logic [PE_NB*17-1:0]   a_o,
    input  logic                  a_shift_i,
    output logic [16:0]           b_o,
    output logic [16:0]           p_o,
    input  logic                  b_fetch_i,
    input  logic                  p_fetch_i,
    input  logic                  RES_push_i,
    input  logic [16:0]           RES_i,
    input  logic                  done_i,
    output logic                  res_valid_o,
    output logic [16:0]           res_data_o,
    input  logic                  res_ready_i
`ifdef FIOS_OPSRV_ERR_EN
    ,
    output logic                  err_o
`endif
);

    localparam int CW   = $clog2(s + 1);
    localparam int IW   = (s > 1) ? $clog2(s) : 1;
    localparam int KMAX = (s + PE_NB - 1) / PE_NB;
    localparam int KW   = $clog2(KMAX + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, OUT} state_t;

    state_t state, state_n;

    logic [16:0] a_buf [s];
    logic [16:0] b_buf [s];
    logic [16:0] p_buf [s];
    logic [16:0] res_buf [s];

    logic [CW-1:0] na, nb, np, wr_cnt, wr_cnt_n, rd_idx, cnt_sel;
    logic [KW-1:0] k, k_n;
    logic [IW-1:0] b_idx, b_idx_n, p_idx, p_idx_n;

    logic [PE_NB*17-1:0] win_n;
    logic ld_fire, ld_ok, full, go_ok, run, push_ok, hs, last, keep;

    always_comb begin
        cnt_sel = CW'(s);
        case (ld_sel_i)
            2'd0:    cnt_sel = na;
            2'd1:    cnt_sel = nb;
            2'd2:    cnt_sel = np;
            default: cnt_sel = CW'(s);
        endcase
    end

    assign ld_fire  = (state == IDLE) && ld_valid_i && (ld_sel_i != 2'd3);
    assign ld_ok    = ld_fire && (cnt_sel != CW'(s));
    assign full     = (na == CW'(s)) && (nb == CW'(s)) && (np == CW'(s));
    assign go_ok    = (state == IDLE) && go_i && full;
    assign run      = (state == RUN);
    assign push_ok  = run && RES_push_i && (wr_cnt != CW'(s));
    assign wr_cnt_n = wr_cnt + CW'(push_ok);
    assign hs       = (state == OUT) && res_ready_i;
    assign last     = hs && (rd_idx + CW'(1) == wr_cnt);

    // k saturates once the window is wholly past the operand: a_o is all zero from there on
    assign k_n = go_ok ? '0 :
                 (run && a_shift_i && k != KW'(KMAX)) ? k + KW'(1) : k;
    assign b_idx_n = go_ok ? '0 :
                     (run && b_fetch_i) ?
                     ((b_idx == IW'(s - 1)) ? '0 : b_idx + IW'(1)) : b_idx;
    assign p_idx_n = go_ok ? '0 :
                     (run && p_fetch_i) ?
                     ((p_idx == IW'(s - 1)) ? '0 : p_idx + IW'(1)) : p_idx;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (go_ok) state_n = START;
            START: state_n = RUN;
            RUN:   if (done_i) state_n = (wr_cnt_n == '0) ? IDLE : OUT;
            OUT:   if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        win_n = '0;
        for (int j = 0; j < PE_NB; j++) begin
            if (int'(k_n) * PE_NB + j < s)
                win_n[17*j +: 17] = a_buf[IW'(int'(k_n) * PE_NB + j)];
        end
    end

    assign keep = (state_n == START) || (state_n == RUN);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            na     <= '0;
            nb     <= '0;
            np     <= '0;
            k      <= '0;
            b_idx  <= '0;
            p_idx  <= '0;
            wr_cnt <= '0;
            rd_idx <= '0;
            a_o    <= '0;
            b_o    <= '0;
            p_o    <= '0;
        end else begin
            if (go_ok) begin
                na     <= '0;
                nb     <= '0;
                np     <= '0;
                wr_cnt <= '0;
                rd_idx <= '0;
            end else begin
                if (ld_ok && ld_sel_i == 2'd0) na <= na + CW'(1);
                if (ld_ok && ld_sel_i == 2'd1) nb <= nb + CW'(1);
                if (ld_ok && ld_sel_i == 2'd2) np <= np + CW'(1);
                wr_cnt <= wr_cnt_n;
                if (hs) rd_idx <= rd_idx + CW'(1);
            end
            k     <= k_n;
            b_idx <= b_idx_n;
            p_idx <= p_idx_n;
            a_o   <= keep ? win_n : '0;
            b_o   <= keep ? b_buf[b_idx_n] : '0;
            p_o   <= keep ? p_buf[p_idx_n] : '0;
        end
    end

    // Buffer contents survive reset
    always_ff @(posedge clock_i) begin
        if (ld_ok && ld_sel_i == 2'd0) a_buf[cnt_sel[IW-1:0]] <= ld_data_i;
        if (ld_ok && ld_sel_i == 2'd1) b_buf[cnt_sel[IW-1:0]] <= ld_data_i;
        if (ld_ok && ld_sel_i == 2'd2) p_buf[cnt_sel[IW-1:0]] <= ld_data_i;
        if (push_ok) res_buf[wr_cnt[IW-1:0]] <= RES_i;
    end

    assign ld_ready_o  = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign start_o     = (state == START);
    assign res_valid_o = (state == OUT);
    assign res_data_o  = (state == OUT) ? res_buf[rd_idx[IW-1:0]] : '0;

`ifdef FIOS_OPSRV_ERR_EN
    logic err_set;

    assign err_set = (ld_fire && !ld_ok)
                   || ((state == IDLE) && go_i && !full)
                   || (!run && (a_shift_i || b_fetch_i || p_fetch_i || RES_push_i))
                   || (run && RES_push_i && wr_cnt == CW'(s))
                   || (run && a_shift_i && k == KW'(KMAX));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)      err_o <= 1'b0;
        else if (err_set) err_o <= 1'b1;
    end
`endif

endmodule

// File: doc/fios_operand_server.md
# fios_operand_server

Host-side companion to the cascaded FIOS Montgomery multiplier. It buffers operands a, b and p loaded word-by-word by a host, and launches a multiplication with a `start_o` pulse. While the core runs, it answers the core's `a_shift`/`b_fetch`/`p_fetch` requests and collects the result words the core pushes, then streams the result back to the host over a valid/ready port. It sits between the host bus adapter and the FIOS core top level.

## Interface
- `s`, 8: operand length in 17-bit words.
- `PE_NB`, 8: number of processing elements; sets the width of the a window.
- `clock_i` in 1: single clock domain.
- `reset_i` in 1: asynchronous, active-high reset.
- `ld_valid_i` in 1: host load word valid.
- `ld_sel_i` in 2: load target: 0 = a, 1 = b, 2 = p, 3 = ignored.
- `ld_data_i` in 17: load word; least significant word first.
- `ld_ready_o` out 1: load accepted this cycle when high together with `ld_valid_i`.
- `go_i` in 1: host request to start a multiplication.
- `busy_o` out 1: high in every state except IDLE.
- `start_o` out 1: one-cycle start pulse to the core.
- `a_o` out PE_NB*17: current a window; word j in bits [17j+16:17j].
- `a_shift_i` in 1: core request to advance the a window.
- `b_o`, `p_o` out 17: current b and p words.
- `b_fetch_i`, `p_fetch_i` in 1: core requests to advance the b and p indices.
- `RES_push_i` in 1, `RES_i` in 17: result word push from the core.
- `done_i` in 1: core completion pulse.
- `res_valid_o` out 1, `res_data_o` out 17, `res_ready_i` in 1: result stream to the host.

## Operation
- Storage: three s×17 buffers (a, b, p) and one s×17 result buffer.
- Load counters `na`, `nb`, `np` range 0..s.
- FSM states: IDLE, START, RUN, OUT.
- IDLE:
  - `ld_ready_o` = 1.
  - An accepted load writes `buf[sel][n_sel]` and increments `n_sel`.
  - A load with `n_sel == s` is dropped.
  - `go_i` is accepted only when `na == nb == np == s`; otherwise it is ignored.
- IDLE→START on an accepted go. On that edge:
  - `na`, `nb`, `np` are cleared. Every run requires a full reload.
  - The window index k, `b_idx`, `p_idx`, `wr_cnt` and `rd_idx` are cleared.
- START: `start_o` = 1 for exactly this one cycle; the FSM then goes to RUN.
- RUN:
  - `a_o` word j = `a_buf[k*PE_NB + j]`, or 0 when the index is ≥ s. `a_shift_i` increments k.
  - `b_o` = `b_buf[b_idx]`. `b_fetch_i` advances `b_idx` modulo s, wrapping s-1→0 because b is re-read on every outer iteration.
  - `p_o` and `p_fetch_i` behave identically with `p_idx`.
  - `RES_push_i` writes `res_buf[wr_cnt]` and increments `wr_cnt`. Pushes with `wr_cnt == s` are dropped.
  - `done_i` moves the FSM to OUT, or to IDLE when `wr_cnt` is 0 after this cycle's push.
- OUT:
  - `res_valid_o` = 1 and `res_data_o` = `res_buf[rd_idx]`.
  - A valid&ready handshake increments `rd_idx`.
  - The handshake that moves `rd_idx` to `wr_cnt` returns the FSM to IDLE.
- Fetch, shift and push inputs are ignored outside RUN.
- `go_i` is ignored outside IDLE.

## Timing
- Reset values (asynchronous):
  - FSM = IDLE; all counters and indices = 0.
  - `ld_ready_o` = 1, `busy_o` = 0, `start_o` = 0, `res_valid_o` = 0.
  - `a_o`, `b_o`, `p_o` and `res_data_o` = 0.
  - Buffer contents are not reset.
- Reset mid-run aborts immediately; the next run needs a full reload.
- `start_o` is high in the cycle after the edge where go was accepted.
- `a_o`, `b_o` and `p_o` are registered. An update takes effect one cycle after the edge on which the request is sampled high.
- Simultaneous `RES_push_i` and `done_i` in one cycle: the word is stored before the OUT transition, and that word is included in the stream.
- The first result word appears in the cycle after `done_i`. One word is transferred per cycle while `res_ready_i` is held high.

## Configuration
- `FIOS_OPSRV_ERR_EN` defined: adds output `err_o` (1 bit, reset 0). It is sticky until reset and is set on any of:
  - a dropped load;
  - `go_i` in IDLE with incomplete operands;
  - `a_shift_i`, `b_fetch_i`, `p_fetch_i` or `RES_push_i` outside RUN;
  - a dropped push;
  - k advancing past ⌈s/PE_NB⌉.
- Not defined: `err_o` is absent, and all of these violations are silently ignored as described above.

## Test plan
- s=8, PE_NB=8, load a = 0..7, b = 0x10..0x17, p = 0x20..0x27, then pulse go → `start_o` is one cycle exactly one cycle after go; `a_o` holds words 0..7; `b_o` = 0x10 and `p_o` = 0x20.
- 9 `b_fetch_i` pulses in RUN → `b_o` steps 0x11..0x17, then 0x10, 0x11 (wrap).
- 8 `RES_push_i` words 0x100..0x107, then `done_i`; hold `res_ready_i` = 1 → 8 consecutive `res_valid_o` cycles with data 0x100..0x107, then `busy_o` = 0.
- Push on the same cycle as `done_i` after 7 prior pushes → 8 words stream out, the last being the simultaneous push.
- Load only 7 words of p, then go → no `start_o`, `busy_o` stays 0, `err_o` = 1 with the macro defined.
- Assert `reset_i` asynchronously mid-RUN → all outputs return to reset values without waiting for a clock edge; a subsequent go without reload is ignored.
